// File: rtl/ms_chk_pkg.sv
// Shared definitions for the master-slave SR flip-flop checker:
// FSM state encoding, {R,S} input codes and default parameter values.
package ms_chk_pkg;

    typedef enum logic [1:0] {
        TRACK = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2
    } chk_state_e;

    // Input codes are written as {R,S}; both inputs are active-low.
    localparam logic [1:0] SR_HOLD = 2'b11;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_RST  = 2'b01;
    localparam logic [1:0] SR_FORB = 2'b00;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CHECK_DELAY = 4;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/ms_chk_sync.sv
// N-stage synchronizer bringing one asynchronous flip-flop signal into the
// checker clock domain. The reset value is chosen per signal so that the
// active-low S/R inputs come out of reset in their inactive state.
module ms_chk_sync
    import ms_chk_pkg::*;
#(
    parameter int   STAGES    = DEF_SYNC_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ms_sr_checker.sv
// On-chip monitor for a master-slave SR flip-flop. Oversamples S, R, C, Q and
// Qn, runs a golden master/slave model, checks the real outputs a fixed delay
// after every C falling edge and keeps saturating event counters for debug.
module ms_sr_checker
    import ms_chk_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CHECK_DELAY = DEF_CHECK_DELAY,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S,
    input  logic             R,
    input  logic             C,
    input  logic             Q,
    input  logic             Qn,
    output logic             model_q,
    output logic             model_valid,
    output logic             err,
    output logic             forbidden,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] forb_cnt,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       DLY_LOAD = 4'(CHECK_DELAY);

    logic sSync, rSync, cSync, qSync, qnSync;

    logic             cPrev_q;
    logic             master_q, masterValid_q;
    logic             modelQ_q, modelValid_q;
    logic             forbidden_q, inForb_q;
    logic [CNT_W-1:0] errCnt_q, forbCnt_q, edgeCnt_q;
    chk_state_e       state_q, state_d;
    logic [3:0]       dly_q, dly_d;

    logic [1:0] srCode;
    logic       fallEdge;
    logic       forbNow;
    logic       forbEntry;
    logic       mismatch;
    logic       checkFail;

    ms_chk_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_s (
        .clk(clk), .rst(rst), .d_i(S), .q_o(sSync)
    );
    ms_chk_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_r (
        .clk(clk), .rst(rst), .d_i(R), .q_o(rSync)
    );
    ms_chk_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_c (
        .clk(clk), .rst(rst), .d_i(C), .q_o(cSync)
    );
    ms_chk_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_q (
        .clk(clk), .rst(rst), .d_i(Q), .q_o(qSync)
    );
    ms_chk_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_qn (
        .clk(clk), .rst(rst), .d_i(Qn), .q_o(qnSync)
    );

    assign srCode    = {rSync, sSync};
    assign fallEdge  = cPrev_q & ~cSync;
    assign forbNow   = cSync & (srCode == SR_FORB);
    assign forbEntry = forbNow & ~inForb_q;
    assign mismatch  = (qSync != modelQ_q) | (qnSync != ~modelQ_q);

    // Master latch model: follows S/R while C is high, holds while C is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            master_q      <= 1'b0;
            masterValid_q <= 1'b0;
        end else if (cSync) begin
            case (srCode)
                SR_SET: begin
                    master_q      <= 1'b1;
                    masterValid_q <= 1'b1;
                end
                SR_RST: begin
                    master_q      <= 1'b0;
                    masterValid_q <= 1'b1;
                end
                SR_FORB: begin
                    masterValid_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Slave capture on C falling edges, forbidden tracking and saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cPrev_q      <= 1'b0;
            inForb_q     <= 1'b0;
            modelQ_q     <= 1'b0;
            modelValid_q <= 1'b0;
            forbidden_q  <= 1'b0;
            errCnt_q     <= '0;
            forbCnt_q    <= '0;
            edgeCnt_q    <= '0;
        end else begin
            cPrev_q  <= cSync;
            inForb_q <= forbNow;
            if (fallEdge) begin
                modelQ_q     <= master_q;
                modelValid_q <= masterValid_q;
                if (edgeCnt_q != CNT_MAX) begin
                    edgeCnt_q <= edgeCnt_q + CNT_ONE;
                end
            end
            if (forbNow) begin
                forbidden_q <= 1'b1;
            end else if (fallEdge && masterValid_q) begin
                forbidden_q <= 1'b0;
            end
            if (forbEntry && (forbCnt_q != CNT_MAX)) begin
                forbCnt_q <= forbCnt_q + CNT_ONE;
            end
            if (checkFail && (errCnt_q != CNT_MAX)) begin
                errCnt_q <= errCnt_q + CNT_ONE;
            end
        end
    end

    // Check FSM state and delay counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TRACK;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
        end
    end

    // Check FSM next-state: wait out the settle delay after each fall, then compare once.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        checkFail = 1'b0;
        case (state_q)
            TRACK: begin
                if (fallEdge) begin
                    state_d = WAIT;
                    dly_d   = DLY_LOAD;
                end
            end
            WAIT: begin
                if (fallEdge) begin
                    dly_d = DLY_LOAD;
                end else if (dly_q <= 4'd1) begin
                    state_d = CHECK;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end
            CHECK: begin
                if (fallEdge) begin
                    state_d = WAIT;
                    dly_d   = DLY_LOAD;
                end else begin
                    state_d   = TRACK;
                    checkFail = modelValid_q & mismatch;
                end
            end
            default: begin
                state_d = TRACK;
                dly_d   = '0;
            end
        endcase
    end

    assign model_q     = modelQ_q;
    assign model_valid = modelValid_q;
    assign err         = checkFail;
    assign forbidden   = forbidden_q;
    assign err_cnt     = errCnt_q;
    assign forb_cnt    = forbCnt_q;
    assign edge_cnt    = edgeCnt_q;

endmodule

// File: doc/ms_sr_checker.md
Name: ms_sr_checker

Overview:
- Synthesizable on-chip monitor for the master-slave SR flip-flop; it is the reader end of that flip-flop's S/R/C interface.
- Oversamples the flip-flop's active-low S and R, its clock C, and its outputs Q/Qn on a fast system clock.
- Runs a golden master-slave model, flags output mismatches and illegal input combinations, and keeps event counters for board-level LED/7-seg debug.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for S, R, C, Q, Qn (allowed range 2..3).
- CHECK_DELAY, 4, clk cycles after a C falling edge before Q/Qn are compared (range 1..15).
- CNT_W, 8, width of all event counters (saturating).

Ports:
- clk  input  1  system clock; must be at least 4x faster than C.
- rst  input  1  asynchronous, active-high reset.
- S  input  1  flip-flop set input, active-low (0 = set).
- R  input  1  flip-flop reset input, active-low (0 = reset).
- C  input  1  flip-flop clock, sampled as data.
- Q  input  1  flip-flop output.
- Qn  input  1  flip-flop complementary output.
- model_q  output  1  golden slave state.
- model_valid  output  1  1 when model_q is defined.
- err  output  1  one-clk pulse on a failed check.
- forbidden  output  1  level; S=R=0 seen while the master is open since the last valid capture.
- err_cnt  output  CNT_W  failed checks.
- forb_cnt  output  CNT_W  forbidden episodes.
- edge_cnt  output  CNT_W  C falling edges observed.

Behaviour:
- Sampling: all five inputs pass through SYNC_STAGES flops; the suffix _s below means the synchronized version. c_d is C_s delayed one clk; a falling edge is c_d=1 and C_s=0.
- Reset (async, any time, including mid-check):
  - model_q=0, model_valid=0, master=0, master_valid=0.
  - err=0, forbidden=0, all counters 0, FSM to TRACK, delay counter 0.
- Master model, updated every clk while C_s=1:
  - S_s=0, R_s=1: master=1, master_valid=1.
  - S_s=1, R_s=0: master=0, master_valid=1.
  - S_s=1, R_s=1: hold.
  - S_s=0, R_s=0: master_valid=0 and forbidden=1. forb_cnt increments once per episode, on entry to this combination only.
  - While C_s=0 the master holds and the inputs are ignored.
- Slave capture, on a C falling edge:
  - model_q=master, model_valid=master_valid.
  - edge_cnt increments.
  - forbidden clears only if master_valid=1.
- FSM states:
  - TRACK: on a falling edge, load the delay counter with CHECK_DELAY and go to WAIT.
  - WAIT: decrement each clk; at 0 go to CHECK.
  - CHECK (one clk): if model_valid=1 and (Q_s != model_q or Qn_s != ~model_q), pulse err and increment err_cnt. If model_valid=0, perform no check. Return to TRACK.
  - A falling edge arriving in WAIT or CHECK restarts WAIT with a full CHECK_DELAY. The pending check is dropped and the new edge is counted.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Simultaneous events in one clk: forbidden entry and a falling edge cannot coincide, because entry requires C_s=1 in that cycle and the edge is evaluated with C_s=0. A master update and a slave capture in the same cycle are likewise impossible.
- Latency: err asserts SYNC_STAGES+CHECK_DELAY+1 clk after the C fall at the pin.
- Pulses on S/R shorter than 1 clk may be missed; this is documented as a limitation, not an error.

Decomposition:
- Package ms_chk_pkg holds:
  - the FSM state enum (TRACK, WAIT, CHECK);
  - SR input-code constants (SR_HOLD=2'b11, SR_SET=2'b10 as {R,S}={1,0}, SR_RST=2'b01, SR_FORB=2'b00);
  - the default parameter values.
- One sub-module, ms_chk_sync: a parameterized N-stage synchronizer instanced per input, with the async reset clearing it to 1 for S/R and to 0 for C/Q/Qn.

Test Plan:
- Clean set/reset: C period 40 ns, {R,S}=10 for one high phase, then 11, then 01. Required: model_q 1 then 0, model_valid=1 after the first edge. A correct DUT gives err_cnt=0 and edge_cnt equal to the number of falls.
- Mismatch injection: force Q=0/Qn=1 after a set edge. Required: exactly one err pulse CHECK_DELAY+SYNC_STAGES+1 clk after the fall, and err_cnt=1.
- Forbidden: {R,S}=00 during C high, then 11 before the fall. Required: forbidden=1, forb_cnt=1, model_valid=0 after the fall, no err. A later {R,S}=10 phase restores model_valid=1 and clears forbidden.
- Ones-catching: a 5 ns S=0 pulse (at least 1 clk wide) during C high, then 11. Required: model_q=1 after the fall. The same pulse during C low leaves model_q unchanged.
- Saturation and reset: CNT_W=2, run 5 mismatch edges. Required: err_cnt=3. Assert rst mid-WAIT. Required: all outputs 0 immediately, and no err pulse follows.
